wb_arbiter: RTL and testbench

Writeback stage directly upstream of the register file. It merges single-cycle ALU results and variable-latency load results onto the register file's single write port. ALU results always win. Load results wait in a small FIFO, and a younger ALU write squashes any older queued load to the same register. Outputs are registered on the rising edge, so the register file captures them on the following falling edge.

---
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto one register-file write port.
// Optional operand forwarding outputs are enabled with the WB_FORWARD_EN macro.
module wb_arbiter #(
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned REGFILE_ADDR_BITS = 3,
    parameter int unsigned LQ_DEPTH          = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] alu_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [REGFILE_ADDR_BITS-1:0] ld_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    ld_data,
    output logic                         write_enable,
    output logic [REGFILE_ADDR_BITS-1:0] write_addr,
    output logic [DATA_BUS_WIDTH-1:0]    write_data,
`ifdef WB_FORWARD_EN
    input  logic [REGFILE_ADDR_BITS-1:0] fwd_addr1,
    input  logic [REGFILE_ADDR_BITS-1:0] fwd_addr2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_BUS_WIDTH-1:0]    fwd_data1,
    output logic [DATA_BUS_WIDTH-1:0]    fwd_data2,
`endif
    output logic                         pending
);

    localparam int unsigned PtrW = $clog2(LQ_DEPTH);
    localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);

    logic [LQ_DEPTH-1:0]          live_q, live_d;
    logic [REGFILE_ADDR_BITS-1:0] addr_q [LQ_DEPTH];
    logic [REGFILE_ADDR_BITS-1:0] addr_d [LQ_DEPTH];
    logic [DATA_BUS_WIDTH-1:0]    data_q [LQ_DEPTH];
    logic [DATA_BUS_WIDTH-1:0]    data_d [LQ_DEPTH];
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]              count_q, count_d;

    logic                         we_q, we_d;
    logic [REGFILE_ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [DATA_BUS_WIDTH-1:0]    wdata_q, wdata_d;

    logic ld_xfer, q_empty, pop, bypass, push;

    assign ld_ready = (count_q != CntW'(LQ_DEPTH));
    assign ld_xfer  = ld_valid && ld_ready;
    assign q_empty  = (count_q == '0);
    assign pop      = !alu_valid && !q_empty;
    assign bypass   = !alu_valid && q_empty && ld_xfer;
    assign push     = ld_xfer && !bypass;

    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (alu_valid) begin
            we_d    = (alu_addr != '0);
            waddr_d = alu_addr;
            wdata_d = alu_data;
            // A younger ALU write makes any queued load to the same register obsolete.
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                if (addr_q[i] == alu_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            we_d     = live_q[rd_ptr_q] && (addr_q[rd_ptr_q] != '0);
            waddr_d  = addr_q[rd_ptr_q];
            wdata_d  = data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else if (bypass) begin
            we_d    = (ld_addr != '0);
            waddr_d = ld_addr;
            wdata_d = ld_data;
        end

        if (push) begin
            // A load arriving alongside an ALU write to the same register is the older one.
            live_d[wr_ptr_q] = !(alu_valid && (ld_addr == alu_addr));
            addr_d[wr_ptr_q] = ld_addr;
            data_d[wr_ptr_q] = ld_data;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign pending      = !q_empty || we_q;

`ifdef WB_FORWARD_EN
    assign fwd_hit1  = we_q && (waddr_q == fwd_addr1) && (fwd_addr1 != '0);
    assign fwd_hit2  = we_q && (waddr_q == fwd_addr2) && (fwd_addr2 != '0);
    assign fwd_data1 = wdata_q;
    assign fwd_data2 = wdata_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed timing checks plus an in-order write scoreboard.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        pending;
`ifdef WB_FORWARD_EN
    logic [2:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
`endif

    wb_arbiter #(
        .DATA_BUS_WIDTH   (16),
        .REGFILE_ADDR_BITS(3),
        .LQ_DEPTH         (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .write_data  (write_data),
`ifdef WB_FORWARD_EN
        .fwd_addr1   (fwd_addr1),
        .fwd_addr2   (fwd_addr2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2),
`endif
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] rf [8];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                         input logic lv, input logic [2:0] la, input logic [15:0] ldd);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ldd;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Every register-file write must match the next expected write, in order.
    always @(negedge clk) begin
        if (!reset && write_enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(write_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_addr", 32'(write_addr), 32'(mon_e.addr));
                check("sb_data", 32'(write_data), 32'(mon_e.data));
            end
            rf[write_addr] = write_data;
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        reset = 1'b1;
        idle();
`ifdef WB_FORWARD_EN
        fwd_addr1 = 3'd0;
        fwd_addr2 = 3'd0;
`endif
        #3;
        check("rst_we", 32'(write_enable), 0);
        check("rst_waddr", 32'(write_addr), 0);
        check("rst_wdata", 32'(write_data), 0);
        check("rst_ready", 32'(ld_ready), 1);
        check("rst_pending", 32'(pending), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ALU only, including a dropped write to r0.
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        expect_wr(3'd3, 16'h1234);
        tick();
        check("alu_we", 32'(write_enable), 1);
        check("alu_addr", 32'(write_addr), 3);
        check("alu_data", 32'(write_data), 32'h1234);
        drive(1'b1, 3'd0, 16'h7777, 1'b0, 3'd0, 16'h0);
        tick();
        check("alu_r0_we", 32'(write_enable), 0);
        check("alu_r0_pending", 32'(pending), 0);
        idle();
        tick();

        // ALU and load collide with an empty queue.
        drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
        expect_wr(3'd1, 16'hAAAA);
        expect_wr(3'd2, 16'h5555);
        tick();
        check("col_we1", 32'(write_enable), 1);
        check("col_addr1", 32'(write_addr), 1);
        check("col_ready", 32'(ld_ready), 1);
        idle();
        tick();
        check("col_we2", 32'(write_enable), 1);
        check("col_addr2", 32'(write_addr), 2);
        check("col_data2", 32'(write_data), 32'h5555);
        tick();
        check("col_idle", 32'(pending), 0);

        // Fill the queue under sustained ALU traffic; drain wraps the pointers.
        drive(1'b1, 3'd6, 16'hA000, 1'b1, 3'd1, 16'h0111);
        expect_wr(3'd6, 16'hA000);
        tick();
        check("full_rdy1", 32'(ld_ready), 1);
        drive(1'b1, 3'd6, 16'hA001, 1'b1, 3'd2, 16'h0222);
        expect_wr(3'd6, 16'hA001);
        tick();
        check("full_rdy2", 32'(ld_ready), 0);
        drive(1'b1, 3'd6, 16'hA002, 1'b1, 3'd3, 16'h0333);
        expect_wr(3'd6, 16'hA002);
        tick();
        check("full_rdy3", 32'(ld_ready), 0);
        drive(1'b1, 3'd6, 16'hA003, 1'b1, 3'd3, 16'h0333);
        expect_wr(3'd6, 16'hA003);
        tick();
        check("full_rdy4", 32'(ld_ready), 0);
        check("full_pending", 32'(pending), 1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h0333);
        expect_wr(3'd1, 16'h0111);
        expect_wr(3'd2, 16'h0222);
        expect_wr(3'd3, 16'h0333);
        tick();
        check("drain_addr1", 32'(write_addr), 1);
        check("drain_rdy", 32'(ld_ready), 1);
        tick();
        check("drain_addr2", 32'(write_addr), 2);
        idle();
        tick();
        check("drain_addr3", 32'(write_addr), 3);
        check("drain_we3", 32'(write_enable), 1);
        tick();
        check("drain_idle", 32'(pending), 0);

        // A younger ALU write squashes a queued load to the same register.
        drive(1'b1, 3'd7, 16'h0777, 1'b1, 3'd5, 16'h0001);
        expect_wr(3'd7, 16'h0777);
        tick();
        drive(1'b1, 3'd5, 16'h0002, 1'b0, 3'd0, 16'h0);
        expect_wr(3'd5, 16'h0002);
        tick();
        idle();
        tick();
        check("squash_we", 32'(write_enable), 0);
        check("squash_pending", 32'(pending), 0);
        tick();
        check("squash_r5", 32'(rf[5]), 32'h0002);

        // Same-cycle load to the ALU's register is enqueued dead.
        drive(1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 16'h9999);
        expect_wr(3'd4, 16'h4444);
        tick();
        idle();
        tick();
        check("same_sq_we", 32'(write_enable), 0);
        tick();
        check("same_sq_r4", 32'(rf[4]), 32'h4444);

        // Direct bypass: one-cycle load latency with an empty queue.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h2222);
        expect_wr(3'd2, 16'h2222);
        tick();
        check("byp_we", 32'(write_enable), 1);
        check("byp_data", 32'(write_data), 32'h2222);
        idle();
        tick();
        check("byp_idle", 32'(pending), 0);

`ifdef WB_FORWARD_EN
        drive(1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd0, 16'h0);
        expect_wr(3'd4, 16'hBEEF);
        fwd_addr1 = 3'd4;
        fwd_addr2 = 3'd0;
        tick();
        check("fwd_hit1", 32'(fwd_hit1), 1);
        check("fwd_data1", 32'(fwd_data1), 32'hBEEF);
        check("fwd_hit2", 32'(fwd_hit2), 0);
        fwd_addr2 = 3'd3;
        #1;
        check("fwd_hit2_miss", 32'(fwd_hit2), 0);
        idle();
        tick();
        check("fwd_idle_hit1", 32'(fwd_hit1), 0);
`endif

        // Reset mid-burst with two loads queued and an ALU write in flight.
        drive(1'b1, 3'd6, 16'h6001, 1'b1, 3'd1, 16'h1001);
        expect_wr(3'd6, 16'h6001);
        tick();
        drive(1'b1, 3'd6, 16'h6002, 1'b1, 3'd2, 16'h1002);
        tick();
        check("pre_rst_rdy", 32'(ld_ready), 0);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(write_enable), 0);
        check("mid_rst_rdy", 32'(ld_ready), 1);
        check("mid_rst_pending", 32'(pending), 0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_we", 32'(write_enable), 0);
        check("post_rst_pending", 32'(pending), 0);
        tick();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
